// File: rtl/rvv_backend_alu_rs.sv
// ALU reservation station: a circular buffer with up to NUM_DP pushes and NUM_ALU pops per cycle.
// Define RVV_ALU_RS_TRAP_FLUSH_EN to add the trap_flush_rvv port, which empties the station.
module rvv_backend_alu_rs #(
    parameter int  DEPTH    = 8,
    parameter int  NUM_DP   = 2,
    parameter int  NUM_ALU  = 2,
    parameter type ALU_RS_t = logic [31:0]
) (
    input  logic                clk,
    input  logic                rst,
`ifdef RVV_ALU_RS_TRAP_FLUSH_EN
    input  logic                trap_flush_rvv,
`endif
    input  logic [NUM_DP-1:0]   push_dp2rs,
    input  ALU_RS_t             uop_dp2rs [NUM_DP-1:0],
    output logic                fifo_full_rs2dp,
    output logic [NUM_DP-1:1]   fifo_almost_full_rs2dp,
    input  logic [NUM_ALU-1:0]  pop_ex2rs,
    output ALU_RS_t             alu_uop_rs2ex [NUM_ALU-1:0],
    output logic                fifo_empty_rs2ex,
    output logic [NUM_ALU-1:1]  fifo_almost_empty_rs2ex
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ALU_RS_t            mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   free_s;
    logic [CNT_W-1:0]   push_cnt_s;
    logic [CNT_W-1:0]   pop_cnt_s;
    logic [NUM_DP-1:0]  push_ok_s;
    logic [NUM_ALU-1:0] pop_ok_s;
    logic               flush_s;

`ifdef RVV_ALU_RS_TRAP_FLUSH_EN
    assign flush_s = trap_flush_rvv;
`else
    assign flush_s = 1'b0;
`endif

    // Free slots come from the start-of-cycle count, so same-cycle pops never make room for pushes
    assign free_s = CNT_W'(DEPTH) - count_r;

    // Accept push lanes while the request stays contiguous from lane 0 and a free slot remains
    always_comb begin
        logic chain_v;
        push_ok_s  = '0;
        push_cnt_s = '0;
        chain_v    = 1'b1;
        for (int i = 0; i < NUM_DP; i++) begin
            chain_v      = chain_v & push_dp2rs[i] & (free_s > CNT_W'(i));
            push_ok_s[i] = chain_v;
            if (chain_v) begin
                push_cnt_s = push_cnt_s + CNT_W'(1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
    end

    // Perform pop lanes while the request stays contiguous and an occupied entry exists
    always_comb begin
        logic chain_v;
        pop_ok_s  = '0;
        pop_cnt_s = '0;
        chain_v   = 1'b1;
        for (int i = 0; i < NUM_ALU; i++) begin
            chain_v     = chain_v & pop_ex2rs[i] & (count_r > CNT_W'(i));
            pop_ok_s[i] = chain_v;
            if (chain_v) begin
                pop_cnt_s = pop_cnt_s + CNT_W'(1);
            end else begin
                pop_cnt_s = pop_cnt_s;
            end
        end
    end

    // Pointer and occupancy state; reset and flush override any traffic in the same cycle
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt_s);
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
            count_r  <= count_r + push_cnt_s - pop_cnt_s;
        end
    end

    // Entry storage is never cleared; pointer arithmetic wraps naturally at DEPTH
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DP; i++) begin
            if (push_ok_s[i] && !rst && !flush_s) begin
                mem_r[wr_ptr_r + PTR_W'(i)] <= uop_dp2rs[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_ALU; g++) begin : g_out
            assign alu_uop_rs2ex[g] = mem_r[rd_ptr_r + PTR_W'(g)];
        end
        for (g = 1; g < NUM_ALU; g++) begin : g_aempty
            assign fifo_almost_empty_rs2ex[g] = (count_r <= CNT_W'(g));
        end
        for (g = 1; g < NUM_DP; g++) begin : g_afull
            assign fifo_almost_full_rs2dp[g] = (free_s <= CNT_W'(g));
        end
    endgenerate

    assign fifo_empty_rs2ex = (count_r == '0);
    assign fifo_full_rs2dp  = (count_r == CNT_W'(DEPTH));

    rvv_backend_alu_rs_chk #(
        .DEPTH   (DEPTH),
        .NUM_DP  (NUM_DP),
        .NUM_ALU (NUM_ALU),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .push    (push_dp2rs),
        .pop     (pop_ex2rs),
        .count   (count_r)
    );
endmodule

// Protocol checks: push/pop vectors must be thermometer-coded and occupancy stays in range.
module rvv_backend_alu_rs_chk #(
    parameter int DEPTH   = 8,
    parameter int NUM_DP  = 2,
    parameter int NUM_ALU = 2,
    parameter int CNT_W   = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_DP-1:0]  push,
    input logic [NUM_ALU-1:0] pop,
    input logic [CNT_W-1:0]   count
);
    logic [NUM_DP-1:0]  push_inc_s;
    logic [NUM_ALU-1:0] pop_inc_s;

    // A thermometer vector plus one is a power of two, so it shares no set bit with itself
    assign push_inc_s = push + NUM_DP'(1);
    assign pop_inc_s  = pop + NUM_ALU'(1);

    a_push_thermo: assert property (@(posedge clk) disable iff (rst) ((push & push_inc_s) == '0));
    a_pop_thermo:  assert property (@(posedge clk) disable iff (rst) ((pop & pop_inc_s) == '0));
    a_count_range: assert property (@(posedge clk) disable iff (rst) (count <= CNT_W'(DEPTH)));
endmodule

// File: doc/rvv_backend_alu_rs.md
RVV_BACKEND_ALU_RS -- requirements
Module: rvv_backend_alu_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count, power of 2, greater than NUM_DP and greater than NUM_ALU.
REQ-002 SHALL have parameter NUM_DP, default 2: maximum pushes per cycle from dispatch.
REQ-003 SHALL have parameter NUM_ALU, default 2: maximum pops per cycle to the ALU units.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port push_dp2rs, input, NUM_DP bits: push request per lane; thermometer-coded from lane 0.
REQ-007 SHALL have port uop_dp2rs, input, NUM_DP x ALU_RS_t: push payload per lane.
REQ-008 SHALL have port fifo_full_rs2dp, output, 1 bit: no free slot.
REQ-009 SHALL have port fifo_almost_full_rs2dp, output, bits [NUM_DP-1:1]: bit i is 1 when free slots <= i.
REQ-010 SHALL have port pop_ex2rs, input, NUM_ALU bits: pop per ALU lane; thermometer-coded from lane 0.
REQ-011 SHALL have port alu_uop_rs2ex, output, NUM_ALU x ALU_RS_t: lane i carries the entry at head+i.
REQ-012 SHALL have port fifo_empty_rs2ex, output, 1 bit: count == 0.
REQ-013 SHALL have port fifo_almost_empty_rs2ex, output, bits [NUM_ALU-1:1]: bit i is 1 when count <= i.
REQ-014 SHALL have port trap_flush_rvv, input, 1 bit; present only under REQ-032.

Function
REQ-015 SHALL be a circular buffer with rd_ptr and wr_ptr, each of width log2(DEPTH), and a count of width log2(DEPTH)+1.
REQ-016 SHALL accept push lane i only when push_dp2rs[i]=1 and free slots > i, where free slots are computed from the start-of-cycle count.
REQ-017 SHALL write accepted lane i to slot wr_ptr+i (mod DEPTH) and advance wr_ptr by the accepted push count.
REQ-018 SHALL perform pop lane i only when pop_ex2rs[i]=1 and start-of-cycle count > i, then advance rd_ptr by the performed pop count.
REQ-019 SHALL ignore non-thermometer push or pop vectors beyond the first 0 bit; such vectors are a protocol violation flagged by assertion.
REQ-020 SHALL apply simultaneous push and pop in the same cycle: count_next = count + pushes - pops.
REQ-021 SHALL NOT let same-cycle pops free space for same-cycle pushes.
REQ-022 SHALL NOT bypass push data to the outputs: a pushed entry appears on alu_uop_rs2ex one cycle after the push at the earliest.
REQ-023 SHALL derive alu_uop_rs2ex, fifo_empty_rs2ex, fifo_almost_empty_rs2ex, fifo_full_rs2dp and fifo_almost_full_rs2dp combinationally from registered pointers, count and storage only, with no input-to-output path.
REQ-024 SHALL drive stale storage content on alu_uop_rs2ex[i] when count <= i; consumers must not use it.
REQ-025 SHALL wrap both pointers modulo DEPTH, including a multi-lane push or pop that straddles slot DEPTH-1.
REQ-026 SHALL never let count exceed DEPTH or fall below 0.

Reset
REQ-027 SHALL, on a cycle with rst=1, set rd_ptr=0, wr_ptr=0 and count=0, overriding any push, pop or flush in that cycle.
REQ-028 SHALL drive outputs after reset as: fifo_empty_rs2ex=1, fifo_almost_empty_rs2ex all 1, fifo_full_rs2dp=0, fifo_almost_full_rs2dp all 0.
REQ-029 SHALL NOT reset storage contents.
REQ-030 SHALL discard any partially consumed or in-flight state when reset is asserted mid-operation, with no residual entries.

Configuration
REQ-031 SHALL use the macro RVV_ALU_RS_TRAP_FLUSH_EN to select the flush feature.
REQ-032 SHALL, with RVV_ALU_RS_TRAP_FLUSH_EN defined, add port trap_flush_rvv; trap_flush_rvv=1 empties the RS next cycle (pointers=0, count=0), dropping same-cycle pushes and pops.
REQ-033 SHALL, without RVV_ALU_RS_TRAP_FLUSH_EN, omit the trap_flush_rvv port; the RS empties only via pops or rst.

Verification
REQ-034 SHALL cover reset then idle -> empty=1, almost_empty[1]=1, full=0, almost_full[1]=0.
REQ-035 SHALL cover push 2 entries A,B with push=2'b11 -> next cycle alu_uop_rs2ex[0]=A, [1]=B, empty=0, almost_empty[1]=0.
REQ-036 SHALL cover filling to 7 entries, then push=2'b11 -> only lane 0 is accepted, count=8, full=1.
REQ-037 SHALL cover count=8 with push=2'b11 and pop=2'b11 in the same cycle -> no push accepted, count=6, data order preserved.
REQ-038 SHALL cover rd_ptr=7 with count=2 and pop=2'b11 -> slots 7 and 0 are popped, rd_ptr=1, empty=1.
REQ-039 SHALL cover count=5, then flush=1 with RVV_ALU_RS_TRAP_FLUSH_EN defined, or rst=1 -> count=0 and empty=1 next cycle, concurrent push dropped.
